// File: rtl/ram_eraser.sv
// AXI4 write master that fills a memory range with a constant pattern using
// fixed-length INCR bursts, limiting the number of unacknowledged bursts.
module ram_eraser #(
   parameter int unsigned DATA_W          = 512,
   parameter int unsigned BURST_LEN       = 64,
   parameter logic [63:0] RAM_BASE        = 64'h0,
   parameter logic [63:0] RAM_BYTES       = 64'h2_0000_0000,
   parameter int unsigned MAX_OUTSTANDING = 8,
   parameter logic [31:0] FILL            = 32'hFFFF_FFFF
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                erase_ram,
   output logic                erase_idle,
   output logic                erase_error,
   output logic [63:0]         M_AXI_AWADDR,
   output logic [7:0]          M_AXI_AWLEN,
   output logic [2:0]          M_AXI_AWSIZE,
   output logic [1:0]          M_AXI_AWBURST,
   output logic                M_AXI_AWVALID,
   input  logic                M_AXI_AWREADY,
   output logic [DATA_W-1:0]   M_AXI_WDATA,
   output logic [DATA_W/8-1:0] M_AXI_WSTRB,
   output logic                M_AXI_WLAST,
   output logic                M_AXI_WVALID,
   input  logic                M_AXI_WREADY,
   input  logic [1:0]          M_AXI_BRESP,
   input  logic                M_AXI_BVALID,
   output logic                M_AXI_BREADY
);
   localparam logic [63:0]   BURST_BYTES = 64'(BURST_LEN) * 64'(DATA_W / 8);
   localparam logic [63:0]   NBURSTS     = RAM_BYTES / BURST_BYTES;
   localparam int unsigned   CW          = $clog2(NBURSTS + 64'd1);
   localparam int unsigned   BW          = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [CW-1:0] NB          = CW'(NBURSTS);
   localparam logic [BW-1:0] BEAT_LAST   = BW'(BURST_LEN - 1);

   typedef enum logic {IDLE, RUN} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] aw_cnt_q, aw_cnt_d;
   logic [CW-1:0] w_cnt_q, w_cnt_d;
   logic [CW-1:0] b_cnt_q, b_cnt_d;
   logic [CW-1:0] outst_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [63:0]   addr_q, addr_d;
   logic          awvalid_q, awvalid_d;
   logic          wvalid_q, wvalid_d;
   logic          bready_q, bready_d;
   logic          err_q, err_d;
   logic          aw_hs, w_hs, b_hs, wlast, run_d;

   assign M_AXI_AWLEN   = 8'(BURST_LEN - 1);
   assign M_AXI_AWSIZE  = 3'($clog2(DATA_W / 8));
   assign M_AXI_AWBURST = 2'b01;
   assign M_AXI_WDATA   = {(DATA_W / 32){FILL}};
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_WLAST   = wlast;
   assign M_AXI_BREADY  = bready_q;
   assign erase_idle    = (state_q == IDLE);
   assign erase_error   = err_q;

   assign wlast = (beat_q == BEAT_LAST);

   always_comb begin
      aw_hs    = awvalid_q & M_AXI_AWREADY;
      w_hs     = wvalid_q & M_AXI_WREADY;
      b_hs     = bready_q & M_AXI_BVALID;
      state_d  = state_q;
      aw_cnt_d = aw_cnt_q;
      w_cnt_d  = w_cnt_q;
      b_cnt_d  = b_cnt_q;
      beat_d   = beat_q;
      addr_d   = addr_q;
      err_d    = err_q;
      if (state_q == IDLE) begin
         if (erase_ram) begin
            state_d  = RUN;
            aw_cnt_d = '0;
            w_cnt_d  = '0;
            b_cnt_d  = '0;
            beat_d   = '0;
            addr_d   = RAM_BASE;
            err_d    = 1'b0;
         end
      end else begin
         if (aw_hs) begin
            aw_cnt_d = aw_cnt_q + CW'(1);
            addr_d   = addr_q + BURST_BYTES;
         end
         if (w_hs) begin
            beat_d = wlast ? '0 : beat_q + BW'(1);
            if (wlast) w_cnt_d = w_cnt_q + CW'(1);
         end
         if (b_hs) begin
            b_cnt_d = b_cnt_q + CW'(1);
            if (M_AXI_BRESP != 2'b00) err_d = 1'b1;
         end
         if (b_cnt_d == NB) state_d = IDLE;
      end
      // Valids are computed from post-handshake counts so they can be registered
      // without a bubble; once raised they can only fall through their own handshake.
      run_d     = (state_d == RUN);
      outst_d   = aw_cnt_d - b_cnt_d;
      awvalid_d = run_d && (aw_cnt_d < NB) && (32'(outst_d) < MAX_OUTSTANDING);
      wvalid_d  = run_d && (w_cnt_d < aw_cnt_d);
      bready_d  = run_d;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         aw_cnt_q  <= '0;
         w_cnt_q   <= '0;
         b_cnt_q   <= '0;
         beat_q    <= '0;
         addr_q    <= RAM_BASE;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         aw_cnt_q  <= aw_cnt_d;
         w_cnt_q   <= w_cnt_d;
         b_cnt_q   <= b_cnt_d;
         beat_q    <= beat_d;
         addr_q    <= addr_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         err_q     <= err_d;
      end
   end

endmodule
